bcd_down_timer: RTL and testbench

Programmable 3-digit (parameterisable) BCD countdown timer. It is the decrementing counterpart of the chained-BCD 1000:1 divider. It loads a BCD value and decrements it by one on each qualified `tick`, for example the divider's `OneHertz` output, using a borrow chain across digits. It signals expiry with a one-cycle `done` pulse and optionally reloads for periodic operation. It sits downstream of the tick generator in the timekeeping path.

---
 rtl/bcd_down_timer.sv | 136 +++++++++++++
 tb/tb_bcd_down_timer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Programmable multi-digit BCD countdown timer with a borrow chain,
// a one-cycle expiry pulse and an optional periodic reload.
module bcd_down_timer #(
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  tick,
   input  logic                  reload_en,
   output logic [4*DIGITS-1:0]   count,
   output logic [DIGITS-1:0]     b_enable,
   output logic                  busy,
   output logic                  done
);

   localparam int W = 4 * DIGITS;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   reload_q, reload_d;
   logic           done_q, done_d;

   logic [W-1:0]   clamp_val;
   logic [W-1:0]   dec_val;
   logic           run;
   logic           qual_tick;
   logic           at_one;
   logic           clamp_zero;
   logic           borrow;

   assign run        = (state_q == RUN);
   assign qual_tick  = run & tick & ~load & ~stop;
   assign at_one     = (count_q == W'(1));
   assign clamp_zero = (clamp_val == '0);

   // Non-decimal digits saturate at 9 rather than wrapping.
   always_comb begin
      clamp_val = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            clamp_val[4*i +: 4] = 4'd9;
         end
      end
   end

   always_comb begin
      b_enable = '0;
      borrow   = qual_tick;
      for (int i = 0; i < DIGITS; i++) begin
         b_enable[i] = borrow;
         borrow      = borrow & (count_q[4*i +: 4] == 4'd0);
      end
   end

   always_comb begin
      dec_val = count_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (b_enable[i]) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         count_d  = clamp_val;
         reload_d = clamp_val;
         if (run && clamp_zero) begin
            state_d = IDLE;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && (count_q != '0)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state_d = IDLE;
               end else if (tick) begin
                  if (at_one) begin
                     done_d = 1'b1;
                     // Periodic mode skips the 0 so the period is N ticks.
                     if (reload_en) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = IDLE;
                     end
                  end else begin
                     count_d = dec_val;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign count = count_q;
   assign busy  = run;
   assign done  = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: each scenario queues expected
// outputs as it drives a cycle and compares them after the edge.
module tb_bcd_down_timer;

   logic        clk;
   logic        resetn;
   logic        load;
   logic [11:0] load_val;
   logic        start;
   logic        stop;
   logic        tick;
   logic        reload_en;
   logic [11:0] count;
   logic [2:0]  b_enable;
   logic        busy;
   logic        done;

   int tests;
   int fails;

   typedef struct {
      logic        ld;
      logic [11:0] lv;
      logic        st;
      logic        sp;
      logic        tk;
      logic        re;
      logic        rn;
      logic [11:0] ec;
      logic        eb;
      logic        ed;
      logic [2:0]  ebe;
   } row_t;

   row_t sb[$];

   bcd_down_timer #(.DIGITS(3)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .load      (load),
      .load_val  (load_val),
      .start     (start),
      .stop      (stop),
      .tick      (tick),
      .reload_en (reload_en),
      .count     (count),
      .b_enable  (b_enable),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic row_t mk(
      logic ld, logic [11:0] lv, logic st, logic sp, logic tk,
      logic re, logic rn, logic [11:0] ec, logic eb, logic ed,
      logic [2:0] ebe);
      row_t r;
      r.ld = ld; r.lv = lv; r.st = st; r.sp = sp; r.tk = tk;
      r.re = re; r.rn = rn; r.ec = ec; r.eb = eb; r.ed = ed;
      r.ebe = ebe;
      return r;
   endfunction

   function automatic logic [11:0] to_bcd(int n);
      logic [11:0] v;
      v[3:0]  = 4'(n % 10);
      v[7:4]  = 4'((n / 10) % 10);
      v[11:8] = 4'((n / 100) % 10);
      return v;
   endfunction

   task automatic apply(row_t r);
      load      = r.ld;
      load_val  = r.lv;
      start     = r.st;
      stop      = r.sp;
      tick      = r.tk;
      reload_en = r.re;
      resetn    = r.rn;
   endtask

   task automatic test_reset();
      row_t rows[$];
      row_t e;
      rows.push_back(mk(0, 12'h000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL reset[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL reset[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_basic();
      row_t rows[$];
      row_t e;
      rows.push_back(mk(1, 12'h005, 0, 0, 0, 0, 1, 12'h005, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h005, 1, 0, 3'b000));
      for (int k = 1; k <= 5; k++) begin
         rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, to_bcd(5 - k),
                           k < 5, k == 5, 3'b001));
         for (int j = 0; j < 2; j++) begin
            rows.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, to_bcd(5 - k),
                              k < 5, 0, 3'b000));
         end
      end
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL basic[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL basic[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_borrow();
      row_t rows[$];
      row_t e;
      rows.push_back(mk(1, 12'h100, 0, 0, 0, 0, 1, 12'h100, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h100, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h099, 1, 0, 3'b111));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h098, 1, 0, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 1, 0, 0, 1, 12'h098, 0, 0, 3'b000));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL borrow[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL borrow[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_clamp_zero();
      row_t rows[$];
      row_t e;
      rows.push_back(mk(1, 12'h0C3, 0, 0, 0, 0, 1, 12'h093, 0, 0, 3'b000));
      rows.push_back(mk(1, 12'hFFF, 0, 0, 0, 0, 1, 12'h999, 0, 0, 3'b000));
      rows.push_back(mk(1, 12'h000, 0, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h000, 0, 0, 3'b000));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL clamp[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL clamp[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_priority();
      row_t rows[$];
      row_t e;
      rows.push_back(mk(1, 12'h050, 0, 0, 0, 0, 1, 12'h050, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h050, 1, 0, 3'b000));
      rows.push_back(mk(1, 12'h020, 0, 0, 1, 0, 1, 12'h020, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 1, 1, 0, 1, 12'h020, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h020, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h020, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h019, 1, 0, 3'b011));
      rows.push_back(mk(1, 12'h000, 0, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(1, 12'h003, 0, 0, 0, 0, 1, 12'h003, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 1, 0, 1, 12'h003, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h002, 1, 0, 3'b001));
      rows.push_back(mk(0, 12'h000, 1, 1, 0, 0, 1, 12'h002, 0, 0, 3'b000));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL priority[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL priority[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_reload();
      row_t rows[$];
      row_t e;
      int   c;
      rows.push_back(mk(1, 12'h003, 0, 0, 0, 1, 1, 12'h003, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 1, 1, 12'h003, 1, 0, 3'b000));
      c = 3;
      for (int k = 1; k <= 9; k++) begin
         c = (c == 1) ? 3 : c - 1;
         rows.push_back(mk(0, 12'h000, 0, 0, 1, 1, 1, to_bcd(c),
                           1, (k % 3) == 0, 3'b001));
      end
      rows.push_back(mk(1, 12'h001, 0, 0, 0, 1, 1, 12'h001, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 1, 1, 12'h001, 1, 1, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 1, 1, 12'h001, 1, 1, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h000, 0, 1, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL reload[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL reload[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_full_scale();
      row_t rows[$];
      row_t e;
      int   p;
      logic [2:0] be;
      rows.push_back(mk(1, 12'h999, 0, 0, 0, 0, 1, 12'h999, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h999, 1, 0, 3'b000));
      for (int k = 1; k <= 999; k++) begin
         p     = 1000 - k;
         be[0] = 1'b1;
         be[1] = (p % 10) == 0;
         be[2] = be[1] && (((p / 10) % 10) == 0);
         rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, to_bcd(p - 1),
                           p != 1, p == 1, be));
      end
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL full_scale[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL full_scale[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      row_t rows[$];
      row_t e;
      rows.push_back(mk(1, 12'h047, 0, 0, 0, 0, 1, 12'h047, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h047, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h046, 1, 0, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 0, 12'h000, 0, 0, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      rows.push_back(mk(1, 12'h002, 0, 0, 0, 0, 1, 12'h002, 0, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 1, 0, 0, 0, 1, 12'h002, 1, 0, 3'b000));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 1, 12'h001, 1, 0, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 1, 0, 0, 12'h000, 0, 0, 3'b001));
      rows.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 12'h000, 0, 0, 3'b000));
      foreach (rows[i]) begin
         apply(rows[i]);
         sb.push_back(rows[i]);
         #1;
         tests++;
         if (b_enable !== rows[i].ebe) begin
            fails++;
            $display("FAIL reset_mid_run[%0d] b_enable got %b want %b",
                     i, b_enable, rows[i].ebe);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({count, busy, done} !== {e.ec, e.eb, e.ed}) begin
            fails++;
            $display("FAIL reset_mid_run[%0d] cnt/busy/done got %h/%b/%b want %h/%b/%b",
                     i, count, busy, done, e.ec, e.eb, e.ed);
         end
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      resetn    = 1'b0;
      load      = 1'b0;
      load_val  = '0;
      start     = 1'b0;
      stop      = 1'b0;
      tick      = 1'b0;
      reload_en = 1'b0;
      test_reset();
      test_basic();
      test_borrow();
      test_clamp_zero();
      test_priority();
      test_reload();
      test_full_scale();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
